// File: rtl/fp_divider_iterative.sv
// -----------------------------------------------------------------------------
// fp_divider_iterative
// Single-precision IEEE-754 divider (out = in1 / in2) built around one shared
// radix-2 restoring-division datapath sequenced by a small FSM. One operation
// is in flight at a time; a new one is accepted only while ready is high.
//
// Optional feature macro: FP_DIV_EARLY_EXIT_EN
//   defined   : special operands go UNPACK -> DONE (result 2 cycles after accept)
//   undefined : every operation walks ITERATE and ROUND (fixed 30-cycle latency)
//
// Ports
//   clk               in   clock, all state on posedge
//   rst               in   asynchronous active-high reset
//   valid_data_in     in   operands valid this cycle
//   ready             out  idle, operands can be accepted
//   in1, in2          in   dividend / divisor (IEEE-754 single)
//   rounding_mode     in   RNE=0 RTZ=1 RDN=2 RUP=3 RMM=4, captured at accept
//   out               out  quotient, held until the next completion
//   overflow, underflow, inexact, invalid_operation, divide_by_zero
//                     out  IEEE exception flags, held with out
//   valid_data_out    out  one-cycle pulse when out/flags are updated
// -----------------------------------------------------------------------------
module fp_divider_iterative #(
    parameter int QBITS = 27,
    parameter int EXP_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_data_in,
    output logic        ready,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [2:0]  rounding_mode,
    output logic [31:0] out,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact,
    output logic        invalid_operation,
    output logic        divide_by_zero,
    output logic        valid_data_out
);

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic signed [EXP_W-1:0] EXP_BIAS = EXP_W'(32'sd127);
    localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'(32'sd254);
    localparam logic signed [EXP_W-1:0] EXP_ZERO = EXP_W'(32'sd0);
    localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(32'sd1);

    localparam logic [30:0] MAG_INF     = 31'h7F80_0000;
    localparam logic [30:0] MAG_MAX_FIN = 31'h7F7F_FFFF;
    localparam logic [4:0]  LAST_ITER   = 5'(QBITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_UNPACK  = 3'd1,
        S_ITERATE = 3'd2,
        S_ROUND   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Returns {carry, fraction} after applying the rounding increment.
    function automatic logic [23:0] round_mant(
        input logic [22:0] mant,
        input logic        g,
        input logic        r,
        input logic        s,
        input logic        sign,
        input logic [2:0]  mode
    );
        logic up;
        case (mode)
            RM_RNE:  up = g & (r | s | mant[0]);
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = sign & (g | r | s);
            RM_RUP:  up = ~sign & (g | r | s);
            RM_RMM:  up = g;
            default: up = g & (r | s | mant[0]);
        endcase
        return {1'b0, mant} + {23'h000000, up};
    endfunction

    state_t                  state_q;
    logic [31:0]             a_q, b_q;
    logic [2:0]              mode_q;
    logic                    sign_q;
    logic signed [EXP_W-1:0] exp_q;
    logic [23:0]             mb_q;
    logic [25:0]             rem_q;
    logic [QBITS-1:0]        quo_q;
    logic [4:0]              iter_q;
    logic                    special_q;
    logic [31:0]             res_q;
    logic                    res_of_q, res_uf_q, res_nx_q, res_inv_q, res_dz_q;

    logic [7:0]              a_exp_s, b_exp_s;
    logic [22:0]             a_man_s, b_man_s;
    logic                    a_zero_s, a_den_s, a_inf_s, a_nan_s;
    logic                    b_zero_s, b_den_s, b_inf_s, b_nan_s;
    logic                    sign_s;
    logic signed [EXP_W-1:0] exp_unp_s;
    logic                    special_s, spec_inv_s, spec_dz_s;
    logic [31:0]             spec_res_s;

    // Operand classification and special-case result selection.
    always_comb begin
        a_exp_s  = a_q[30:23];
        b_exp_s  = b_q[30:23];
        a_man_s  = a_q[22:0];
        b_man_s  = b_q[22:0];
        // exponent 0 covers both true zero and flushed denormals
        a_zero_s = (a_exp_s == 8'h00);
        b_zero_s = (b_exp_s == 8'h00);
        a_den_s  = a_zero_s && (a_man_s != 23'h000000);
        b_den_s  = b_zero_s && (b_man_s != 23'h000000);
        a_inf_s  = (a_exp_s == 8'hFF) && (a_man_s == 23'h000000);
        b_inf_s  = (b_exp_s == 8'hFF) && (b_man_s == 23'h000000);
        a_nan_s  = (a_exp_s == 8'hFF) && (a_man_s != 23'h000000);
        b_nan_s  = (b_exp_s == 8'hFF) && (b_man_s != 23'h000000);
        sign_s   = a_q[31] ^ b_q[31];
        exp_unp_s = EXP_W'(a_exp_s) - EXP_W'(b_exp_s) + EXP_BIAS;

        special_s  = 1'b1;
        spec_res_s = 32'h0000_0000;
        spec_inv_s = 1'b0;
        spec_dz_s  = 1'b0;
        if (a_nan_s) begin
            spec_res_s = a_q | 32'h0040_0000;
            spec_inv_s = ~a_q[22];
        end else if (b_nan_s) begin
            spec_res_s = b_q | 32'h0040_0000;
            spec_inv_s = ~b_q[22];
        end else if ((a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            spec_res_s = 32'h7FC0_0000;
            spec_inv_s = 1'b1;
        end else if (b_zero_s && !a_inf_s) begin
            spec_res_s = {sign_s, MAG_INF};
            spec_dz_s  = 1'b1;
        end else if (a_inf_s) begin
            spec_res_s = {sign_s, MAG_INF};
        end else if (a_zero_s || b_inf_s) begin
            spec_res_s = {sign_s, 31'h0000_0000};
        end else begin
            special_s = 1'b0;
        end
    end

    logic [25:0] mb_ext_s, rem_sub_s, rem_nxt_s;
    logic        rem_ge_s;

    // One restoring-division step: trial subtract, keep on success, shift left.
    always_comb begin
        mb_ext_s  = {2'b00, mb_q};
        rem_ge_s  = (rem_q >= mb_ext_s);
        rem_sub_s = rem_q - mb_ext_s;
        if (rem_ge_s) begin
            rem_nxt_s = rem_sub_s << 1'b1;
        end else begin
            rem_nxt_s = rem_q << 1'b1;
        end
    end

    logic [22:0]             mant_s;
    logic                    g_s, rb_s, st_s, grs_s;
    logic signed [EXP_W-1:0] e_norm_s, e_rnd_s;
    logic [23:0]             mant_rnd_s;
    logic [31:0]             rnd_res_s;
    logic                    rnd_of_s, rnd_uf_s, rnd_nx_s;

    // Normalise the quotient, round it and resolve overflow/underflow.
    always_comb begin
        // quotient lies in (0.5, 2); a leading 0 means one extra shift
        if (quo_q[QBITS-1]) begin
            mant_s   = quo_q[QBITS-2 -: 23];
            g_s      = quo_q[2];
            rb_s     = quo_q[1];
            st_s     = quo_q[0] | (rem_q != 26'h0);
            e_norm_s = exp_q;
        end else begin
            mant_s   = quo_q[QBITS-3 -: 23];
            g_s      = quo_q[1];
            rb_s     = quo_q[0];
            st_s     = (rem_q != 26'h0);
            e_norm_s = exp_q - EXP_ONE;
        end
        grs_s      = g_s | rb_s | st_s;
        mant_rnd_s = round_mant(mant_s, g_s, rb_s, st_s, sign_q, mode_q);
        // carry out of the fraction leaves it zero and bumps the exponent
        e_rnd_s    = e_norm_s + EXP_W'(mant_rnd_s[23]);

        rnd_of_s  = 1'b0;
        rnd_uf_s  = 1'b0;
        rnd_nx_s  = grs_s;
        rnd_res_s = {sign_q, e_rnd_s[7:0], mant_rnd_s[22:0]};
        if (e_rnd_s > EXP_MAX) begin
            rnd_of_s = 1'b1;
            rnd_nx_s = 1'b1;
            case (mode_q)
                RM_RTZ:  rnd_res_s = {sign_q, MAG_MAX_FIN};
                RM_RDN:  rnd_res_s = sign_q ? {1'b1, MAG_INF} : {1'b0, MAG_MAX_FIN};
                RM_RUP:  rnd_res_s = sign_q ? {1'b1, MAG_MAX_FIN} : {1'b0, MAG_INF};
                default: rnd_res_s = {sign_q, MAG_INF};
            endcase
        end else if (e_rnd_s <= EXP_ZERO) begin
            // no subnormal outputs: flush to signed zero
            rnd_res_s = {sign_q, 31'h0000_0000};
            rnd_nx_s  = 1'b1;
            rnd_uf_s  = grs_s;
        end else begin
            rnd_res_s = {sign_q, e_rnd_s[7:0], mant_rnd_s[22:0]};
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= S_IDLE;
            ready             <= 1'b1;
            a_q               <= 32'h0;
            b_q               <= 32'h0;
            mode_q            <= RM_RNE;
            sign_q            <= 1'b0;
            exp_q             <= EXP_ZERO;
            mb_q              <= 24'h0;
            rem_q             <= 26'h0;
            quo_q             <= '0;
            iter_q            <= 5'd0;
            special_q         <= 1'b0;
            res_q             <= 32'h0;
            res_of_q          <= 1'b0;
            res_uf_q          <= 1'b0;
            res_nx_q          <= 1'b0;
            res_inv_q         <= 1'b0;
            res_dz_q          <= 1'b0;
            out               <= 32'h0;
            overflow          <= 1'b0;
            underflow         <= 1'b0;
            inexact           <= 1'b0;
            invalid_operation <= 1'b0;
            divide_by_zero    <= 1'b0;
            valid_data_out    <= 1'b0;
        end else begin
            valid_data_out <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (valid_data_in) begin
                        a_q     <= in1;
                        b_q     <= in2;
                        mode_q  <= rounding_mode;
                        ready   <= 1'b0;
                        state_q <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sign_q    <= sign_s;
                    exp_q     <= exp_unp_s;
                    mb_q      <= {1'b1, b_man_s};
                    rem_q     <= {3'b001, a_man_s};
                    quo_q     <= '0;
                    iter_q    <= 5'd0;
                    special_q <= special_s;
                    // special result is staged now; ROUND keeps it when set
                    res_q     <= spec_res_s;
                    res_of_q  <= 1'b0;
                    res_uf_q  <= a_den_s | b_den_s;
                    res_nx_q  <= 1'b0;
                    res_inv_q <= spec_inv_s;
                    res_dz_q  <= spec_dz_s;
`ifdef FP_DIV_EARLY_EXIT_EN
                    state_q   <= special_s ? S_DONE : S_ITERATE;
`else
                    state_q   <= S_ITERATE;
`endif
                end
                S_ITERATE: begin
                    rem_q  <= rem_nxt_s;
                    quo_q  <= {quo_q[QBITS-2:0], rem_ge_s};
                    iter_q <= iter_q + 5'd1;
                    if (iter_q == LAST_ITER) begin
                        state_q <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (!special_q) begin
                        res_q     <= rnd_res_s;
                        res_of_q  <= rnd_of_s;
                        res_uf_q  <= rnd_uf_s | res_uf_q;
                        res_nx_q  <= rnd_nx_s;
                        res_inv_q <= 1'b0;
                        res_dz_q  <= 1'b0;
                    end
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    out               <= res_q;
                    overflow          <= res_of_q;
                    underflow         <= res_uf_q;
                    inexact           <= res_nx_q;
                    invalid_operation <= res_inv_q;
                    divide_by_zero    <= res_dz_q;
                    valid_data_out    <= 1'b1;
                    ready             <= 1'b1;
                    state_q           <= S_IDLE;
                end
                default: begin
                    ready   <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider_iterative.sv
// -----------------------------------------------------------------------------
// tb_fp_divider_iterative
// Directed bench for fp_divider_iterative. Expected results are pushed to a
// scoreboard queue when an operation is accepted and popped when the divider
// pulses valid_data_out. Flags are compared as {ovf, unf, inx, inv, dz}.
// -----------------------------------------------------------------------------
module tb_fp_divider_iterative;

    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;

`ifdef FP_DIV_EARLY_EXIT_EN
    localparam int SPEC_LAT = 2;
`else
    localparam int SPEC_LAT = 30;
`endif
    localparam int NORM_LAT = 30;
    localparam int BUDGET   = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_data_in = 1'b0;
    logic        ready;
    logic [31:0] in1 = 32'h0;
    logic [31:0] in2 = 32'h0;
    logic [2:0]  rounding_mode = 3'b000;
    logic [31:0] out;
    logic        overflow, underflow, inexact, invalid_operation, divide_by_zero;
    logic        valid_data_out;

    fp_divider_iterative dut (
        .clk               (clk),
        .rst               (rst),
        .valid_data_in     (valid_data_in),
        .ready             (ready),
        .in1               (in1),
        .in2               (in2),
        .rounding_mode     (rounding_mode),
        .out               (out),
        .overflow          (overflow),
        .underflow         (underflow),
        .inexact           (inexact),
        .invalid_operation (invalid_operation),
        .divide_by_zero    (divide_by_zero),
        .valid_data_out    (valid_data_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  flags;
        logic [7:0]  lat;
    } exp_t;

    exp_t  sb[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flags_now();
        return {27'h0, overflow, underflow, inexact, invalid_operation, divide_by_zero};
    endfunction

    // Accept one operation; with hold set, valid_data_in stays high with other operands.
    task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] m, input logic [31:0] res, input logic [4:0] fl,
                        input int lat, input bit hold);
        exp_t e;
        @(negedge clk);
        check32({tag, " ready"}, {31'h0, ready}, 32'h1);
        in1 = a;
        in2 = b;
        rounding_mode = m;
        valid_data_in = 1'b1;
        e.res = res;
        e.flags = fl;
        e.lat = 8'(lat);
        sb.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (hold) begin
            in1 = 32'h3F80_0000;
            in2 = 32'h4040_0000;
            rounding_mode = RTZ;
        end else begin
            valid_data_in = 1'b0;
        end
    endtask

    // Wait (bounded) for the result pulse and compare against the scoreboard head.
    task automatic collect();
        exp_t  e;
        string tag;
        int    n;
        bit    seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
            if (valid_data_out) seen = 1'b1;
        end
        valid_data_in = 1'b0;
        e = sb.pop_front();
        tag = tag_q.pop_front();
        check32({tag, " seen"}, {31'h0, seen}, 32'h1);
        if (seen) begin
            check32({tag, " out"}, out, e.res);
            check32({tag, " flags"}, flags_now(), {27'h0, e.flags});
            check32({tag, " latency"}, n, {24'h0, e.lat});
            check32({tag, " ready"}, {31'h0, ready}, 32'h1);
            @(posedge clk);
            #1;
            check32({tag, " pulse"}, {31'h0, valid_data_out}, 32'h0);
        end
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] m, input logic [31:0] res, input logic [4:0] fl,
                       input int lat);
        send(tag, a, b, m, res, fl, lat, 1'b0);
        collect();
    endtask

    initial begin
        int pulses;

        // reset state
        repeat (3) @(negedge clk);
        check32("rst ready", {31'h0, ready}, 32'h1);
        check32("rst out", out, 32'h0);
        check32("rst flags", flags_now(), 32'h0);
        check32("rst valid", {31'h0, valid_data_out}, 32'h0);
        rst = 1'b0;

        // normal datapath
        run("6/2 rne",   32'h40C0_0000, 32'h4000_0000, RNE, 32'h4040_0000, 5'b00000, NORM_LAT);
        run("1/3 rne",   32'h3F80_0000, 32'h4040_0000, RNE, 32'h3EAA_AAAB, 5'b00100, NORM_LAT);
        run("1/3 rtz",   32'h3F80_0000, 32'h4040_0000, RTZ, 32'h3EAA_AAAA, 5'b00100, NORM_LAT);
        run("-1/3 rdn",  32'hBF80_0000, 32'h4040_0000, RDN, 32'hBEAA_AAAB, 5'b00100, NORM_LAT);
        run("-1/3 rup",  32'hBF80_0000, 32'h4040_0000, RUP, 32'hBEAA_AAAA, 5'b00100, NORM_LAT);

        // special cases
        run("1/0",       32'h3F80_0000, 32'h0000_0000, RNE, 32'h7F80_0000, 5'b00001, SPEC_LAT);
        run("0/0",       32'h0000_0000, 32'h0000_0000, RNE, 32'h7FC0_0000, 5'b00010, SPEC_LAT);
        run("snan/1",    32'h7F80_0001, 32'h3F80_0000, RNE, 32'h7FC0_0001, 5'b00010, SPEC_LAT);
        run("inf/2",     32'h7F80_0000, 32'h4000_0000, RNE, 32'h7F80_0000, 5'b00000, SPEC_LAT);
        run("denorm/1",  32'h0000_0001, 32'h3F80_0000, RNE, 32'h0000_0000, 5'b01000, SPEC_LAT);

        // overflow and underflow boundaries
        run("ovf rne",   32'h7F00_0000, 32'h3E80_0000, RNE, 32'h7F80_0000, 5'b10100, NORM_LAT);
        run("ovf rtz",   32'h7F00_0000, 32'h3E80_0000, RTZ, 32'h7F7F_FFFF, 5'b10100, NORM_LAT);
        run("-ovf rup",  32'hFF00_0000, 32'h3E80_0000, RUP, 32'hFF7F_FFFF, 5'b10100, NORM_LAT);
        run("unf grs",   32'h0080_0000, 32'h4040_0000, RNE, 32'h0000_0000, 5'b01100, NORM_LAT);
        run("unf exact", 32'h0080_0000, 32'h4480_0000, RNE, 32'h0000_0000, 5'b00100, NORM_LAT);

        // operands offered while busy are ignored
        send("busy", 32'h40C0_0000, 32'h4000_0000, RNE, 32'h4040_0000, 5'b00000, NORM_LAT, 1'b1);
        collect();
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid_data_out) pulses++;
        end
        check32("busy extra pulses", pulses, 32'h0);

        // reset during ITERATE aborts the operation (previous out is nonzero)
        run("pre-rst 1/3", 32'h3F80_0000, 32'h4040_0000, RNE, 32'h3EAA_AAAB, 5'b00100, NORM_LAT);
        @(negedge clk);
        in1 = 32'h3F80_0000;
        in2 = 32'h4040_0000;
        rounding_mode = RNE;
        valid_data_in = 1'b1;
        @(posedge clk);
        #1;
        valid_data_in = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check32("abort out", out, 32'h0);
        check32("abort flags", flags_now(), 32'h0);
        check32("abort ready", {31'h0, ready}, 32'h1);
        check32("abort valid", {31'h0, valid_data_out}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid_data_out) pulses++;
        end
        check32("abort no pulse", pulses, 32'h0);

        // recovery after the abort
        run("post-rst 6/2", 32'h40C0_0000, 32'h4000_0000, RNE, 32'h4040_0000, 5'b00000, NORM_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
